// File: rtl/exec_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// exec_seq_ctrl_pkg
// Shared definitions for the multi-cycle execution sequencer:
//   - state_e     : 3-bit sequencer state encoding (IDLE=0 ... HALT=7)
//   - HALT_*      : halt reason codes reported on halt_code_o
//   - RETIRE_W_DEF: default width of the retired-instruction counter
//   - is_wait_state(): true for the two states that wait on a memory response
// The PC reset value is not defined here; it stays in the global defines.
// -----------------------------------------------------------------------------
package exec_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_WAIT_I  = 3'd2,
    ST_EXEC    = 3'd3,
    ST_MEM_REQ = 3'd4,
    ST_WAIT_D  = 3'd5,
    ST_WB      = 3'd6,
    ST_HALT    = 3'd7
  } state_e;

  localparam logic [1:0] HALT_NONE   = 2'd0;
  localparam logic [1:0] HALT_EBREAK = 2'd1;
  localparam logic [1:0] HALT_FAULT  = 2'd2;
  localparam logic [1:0] HALT_WDT    = 2'd3;

  localparam int unsigned RETIRE_W_DEF = 64;

  function automatic logic is_wait_state(input state_e st);
    return (st == ST_WAIT_I) || (st == ST_WAIT_D);
  endfunction

endpackage

// File: rtl/exec_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// exec_seq_ctrl_if
// Memory-side handshakes of the sequencer: IFU fetch request/response, the IR
// latch enable and the LSU data request/response. Signal suffixes are from
// the sequencer's point of view.
//   master : the sequencer (drives request valids and the IR latch enable)
//   slave  : the IFU/LSU/IR side
// -----------------------------------------------------------------------------
interface exec_seq_ctrl_if;

  logic ifu_req_valid_o;
  logic ifu_req_ready_i;
  logic ifu_rsp_valid_i;
  logic ifu_rsp_err_i;
  logic inst_latch_en_o;
  logic lsu_req_valid_o;
  logic lsu_req_ready_i;
  logic lsu_rsp_valid_i;
  logic lsu_rsp_err_i;

  modport master (
    output ifu_req_valid_o,
    input  ifu_req_ready_i,
    input  ifu_rsp_valid_i,
    input  ifu_rsp_err_i,
    output inst_latch_en_o,
    output lsu_req_valid_o,
    input  lsu_req_ready_i,
    input  lsu_rsp_valid_i,
    input  lsu_rsp_err_i
  );

  modport slave (
    input  ifu_req_valid_o,
    output ifu_req_ready_i,
    output ifu_rsp_valid_i,
    output ifu_rsp_err_i,
    input  inst_latch_en_o,
    input  lsu_req_valid_o,
    output lsu_req_ready_i,
    output lsu_rsp_valid_i,
    output lsu_rsp_err_i
  );

endinterface

// File: rtl/exec_seq_wdt.sv
// -----------------------------------------------------------------------------
// exec_seq_wdt
// Memory-response watchdog. The counter is cleared on entry to a wait state
// and counts each further cycle spent waiting. expired_o is raised while
// waiting with the count equal to WDT_LIMIT; the sequencer gives a response
// seen in that same cycle priority over the timeout.
// Only instantiated when EXEC_SEQ_CTRL_WDT_EN is defined.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   clear_i      : sequencer enters WAIT_I or WAIT_D at the next edge
//   waiting_i    : sequencer currently in WAIT_I or WAIT_D
//   expired_o    : wait has lasted WDT_LIMIT cycles past entry
// -----------------------------------------------------------------------------
module exec_seq_wdt #(
  parameter int unsigned WDT_LIMIT = 1023,
  parameter int unsigned WDT_W     = 10
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic waiting_i,
  output logic expired_o
);

  localparam logic [WDT_W-1:0] LIMIT_C = WDT_W'(WDT_LIMIT);
  localparam logic [WDT_W-1:0] ONE_C   = {{(WDT_W-1){1'b0}}, 1'b1};

  logic [WDT_W-1:0] cnt_q;
  logic [WDT_W-1:0] cnt_d;
  logic             at_limit_s;

  assign at_limit_s = (cnt_q == LIMIT_C);

  // Next count: clear on entry, count while waiting, saturate at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (waiting_i && !at_limit_s) begin
      cnt_d = cnt_q + ONE_C;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = waiting_i && at_limit_s;

endmodule

// File: rtl/exec_seq_ctrl.sv
// -----------------------------------------------------------------------------
// exec_seq_ctrl
// Multi-cycle sequencer: FETCH -> WAIT_I -> EXEC -> [MEM_REQ -> WAIT_D] -> WB,
// retiring one instruction per pass; halts on ebreak or access fault.
// Optional memory-response watchdog: define EXEC_SEQ_CTRL_WDT_EN.
// Ports:
//   clk_i, rst_i      : clock, synchronous active-high reset
//   bus (master)      : IFU/LSU handshakes and IR latch enable
//   idu_is_load_i     : decoded load        (sampled in EXEC)
//   idu_is_store_i    : decoded store       (sampled in EXEC)
//   idu_is_ebreak_i   : decoded ebreak      (sampled in EXEC, highest priority)
//   wb_en_o           : one-cycle commit pulse (PC unit and register file)
//   busy_o            : not IDLE and not HALT
//   halt_o            : core halted
//   halt_code_o       : 0 none, 1 ebreak, 2 access fault, 3 watchdog
//   retired_o         : committed instruction count (wraps)
// All outputs except inst_latch_en_o are registered from the next state, so
// they follow the state register without decode glitches.
// -----------------------------------------------------------------------------
module exec_seq_ctrl
  import exec_seq_ctrl_pkg::*;
#(
  parameter int unsigned RETIRE_W  = RETIRE_W_DEF,
  parameter int unsigned WDT_LIMIT = 1023,
  parameter int unsigned WDT_W     = 10
) (
  input  logic                clk_i,
  input  logic                rst_i,
  exec_seq_ctrl_if.master     bus,
  input  logic                idu_is_load_i,
  input  logic                idu_is_store_i,
  input  logic                idu_is_ebreak_i,
  output logic                wb_en_o,
  output logic                busy_o,
  output logic                halt_o,
  output logic [1:0]          halt_code_o,
  output logic [RETIRE_W-1:0] retired_o
);

  localparam logic [RETIRE_W-1:0] RETIRE_ONE_C = {{(RETIRE_W-1){1'b0}}, 1'b1};

  state_e              state_q;
  state_e              state_d;
  logic [1:0]          halt_code_q;
  logic [1:0]          halt_code_d;
  logic [RETIRE_W-1:0] retired_q;
  logic                ifu_req_valid_q;
  logic                lsu_req_valid_q;
  logic                wb_en_q;
  logic                busy_q;
  logic                halt_q;
  logic                inst_latch_en_s;
  logic                wdt_expired_s;

`ifdef EXEC_SEQ_CTRL_WDT_EN
  logic wdt_clear_s;
  logic wdt_waiting_s;

  assign wdt_waiting_s = is_wait_state(state_q);
  assign wdt_clear_s   = (state_d != state_q) && is_wait_state(state_d);

  exec_seq_wdt #(
    .WDT_LIMIT (WDT_LIMIT),
    .WDT_W     (WDT_W)
  ) u_wdt (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (wdt_clear_s),
    .waiting_i (wdt_waiting_s),
    .expired_o (wdt_expired_s)
  );
`else
  // Waits are unbounded; the watchdog parameters only matter when it is built.
  logic unused_wdt_cfg_s;
  assign unused_wdt_cfg_s = (WDT_LIMIT < (32'd1 << WDT_W));
  assign wdt_expired_s    = 1'b0;
`endif

  // Next-state, halt reason and IR latch enable.
  always_comb begin
    state_d         = state_q;
    halt_code_d     = halt_code_q;
    inst_latch_en_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (bus.ifu_req_ready_i) begin
          state_d = ST_WAIT_I;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_WAIT_I: begin
        // A response wins over a watchdog timeout in the same cycle.
        if (bus.ifu_rsp_valid_i) begin
          if (bus.ifu_rsp_err_i) begin
            state_d     = ST_HALT;
            halt_code_d = HALT_FAULT;
          end else begin
            state_d         = ST_EXEC;
            inst_latch_en_s = 1'b1;
          end
        end else if (wdt_expired_s) begin
          state_d     = ST_HALT;
          halt_code_d = HALT_WDT;
        end else begin
          state_d = ST_WAIT_I;
        end
      end
      ST_EXEC: begin
        // ebreak halts without commit so the PC keeps the ebreak address.
        if (idu_is_ebreak_i) begin
          state_d     = ST_HALT;
          halt_code_d = HALT_EBREAK;
        end else if (idu_is_load_i || idu_is_store_i) begin
          state_d = ST_MEM_REQ;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM_REQ: begin
        if (bus.lsu_req_ready_i) begin
          state_d = ST_WAIT_D;
        end else begin
          state_d = ST_MEM_REQ;
        end
      end
      ST_WAIT_D: begin
        if (bus.lsu_rsp_valid_i) begin
          if (bus.lsu_rsp_err_i) begin
            state_d     = ST_HALT;
            halt_code_d = HALT_FAULT;
          end else begin
            state_d = ST_WB;
          end
        end else if (wdt_expired_s) begin
          state_d     = ST_HALT;
          halt_code_d = HALT_WDT;
        end else begin
          state_d = ST_WAIT_D;
        end
      end
      ST_WB: begin
        state_d = ST_FETCH;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, halt code and retire counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      halt_code_q <= HALT_NONE;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      halt_code_q <= halt_code_d;
      if (state_q == ST_WB) begin
        retired_q <= retired_q + RETIRE_ONE_C;
      end else begin
        retired_q <= retired_q;
      end
    end
  end

  // Moore outputs registered from the next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ifu_req_valid_q <= 1'b0;
      lsu_req_valid_q <= 1'b0;
      wb_en_q         <= 1'b0;
      busy_q          <= 1'b0;
      halt_q          <= 1'b0;
    end else begin
      ifu_req_valid_q <= (state_d == ST_FETCH);
      lsu_req_valid_q <= (state_d == ST_MEM_REQ);
      wb_en_q         <= (state_d == ST_WB);
      busy_q          <= (state_d != ST_IDLE) && (state_d != ST_HALT);
      halt_q          <= (state_d == ST_HALT);
    end
  end

  assign bus.ifu_req_valid_o = ifu_req_valid_q;
  assign bus.lsu_req_valid_o = lsu_req_valid_q;
  // The IR capture must happen in the response cycle, so it stays
  // combinational; it is masked while reset is applied.
  assign bus.inst_latch_en_o = inst_latch_en_s & ~rst_i;
  assign wb_en_o             = wb_en_q;
  assign busy_o              = busy_q;
  assign halt_o              = halt_q;
  assign halt_code_o         = halt_code_q;
  assign retired_o           = retired_q;

endmodule

// File: tb/tb_exec_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_exec_seq_ctrl
// Directed bench for exec_seq_ctrl. Cycle k is the k-th clock edge after
// rst_i is released; outputs are sampled on the falling edge of cycle k.
// A responder process answers accepted requests one cycle after accept.
// The watchdog cases are built when EXEC_SEQ_CTRL_WDT_EN is defined.
// -----------------------------------------------------------------------------
module tb_exec_seq_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        idu_is_load_i;
  logic        idu_is_store_i;
  logic        idu_is_ebreak_i;
  logic        wb_en_o;
  logic        busy_o;
  logic        halt_o;
  logic [1:0]  halt_code_o;
  logic [63:0] retired_o;

  // Responder controls.
  logic ifu_rsp_on;
  logic ifu_err_inj;
  logic ifu_force;
  logic lsu_rsp_on;
  logic lsu_err_inj;
  logic ifu_acc;
  logic lsu_acc;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int cnt_a;
  int cnt_b;
  int wb_cyc;

  exec_seq_ctrl_if bus ();

  exec_seq_ctrl #(
    .RETIRE_W  (64),
    .WDT_LIMIT (8),
    .WDT_W     (4)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .bus             (bus),
    .idu_is_load_i   (idu_is_load_i),
    .idu_is_store_i  (idu_is_store_i),
    .idu_is_ebreak_i (idu_is_ebreak_i),
    .wb_en_o         (wb_en_o),
    .busy_o          (busy_o),
    .halt_o          (halt_o),
    .halt_code_o     (halt_code_o),
    .retired_o       (retired_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_i);
    cyc++;
  endtask

  task automatic clear_inputs();
    bus.ifu_req_ready_i = 1'b0;
    bus.lsu_req_ready_i = 1'b0;
    idu_is_load_i   = 1'b0;
    idu_is_store_i  = 1'b0;
    idu_is_ebreak_i = 1'b0;
    ifu_rsp_on  = 1'b1;
    ifu_err_inj = 1'b0;
    ifu_force   = 1'b0;
    lsu_rsp_on  = 1'b1;
    lsu_err_inj = 1'b0;
  endtask

  // Two reset edges, release on a falling edge; cycle 1 is the next edge.
  task automatic do_reset();
    rst_i = 1'b1;
    clear_inputs();
    step();
    step();
    rst_i = 1'b0;
    cyc = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ifu_valid"}, {63'd0, bus.ifu_req_valid_o}, 64'd0);
    check_eq({tag, "_lsu_valid"}, {63'd0, bus.lsu_req_valid_o}, 64'd0);
    check_eq({tag, "_wb_en"},     {63'd0, wb_en_o}, 64'd0);
    check_eq({tag, "_busy"},      {63'd0, busy_o}, 64'd0);
    check_eq({tag, "_halt"},      {63'd0, halt_o}, 64'd0);
    check_eq({tag, "_code"},      {62'd0, halt_code_o}, 64'd0);
    check_eq({tag, "_retired"},   retired_o, 64'd0);
  endtask

  // Responder: an accept seen in cycle k yields a response in cycle k+1.
  initial begin
    bus.ifu_rsp_valid_i = 1'b0;
    bus.ifu_rsp_err_i   = 1'b0;
    bus.lsu_rsp_valid_i = 1'b0;
    bus.lsu_rsp_err_i   = 1'b0;
    forever begin
      @(negedge clk_i);
      #1;
      ifu_acc = bus.ifu_req_valid_o & bus.ifu_req_ready_i;
      lsu_acc = bus.lsu_req_valid_o & bus.lsu_req_ready_i;
      @(posedge clk_i);
      #1;
      bus.ifu_rsp_valid_i = (ifu_acc & ifu_rsp_on) | ifu_force;
      bus.ifu_rsp_err_i   = ifu_acc & ifu_rsp_on & ifu_err_inj;
      bus.lsu_rsp_valid_i = lsu_acc & lsu_rsp_on;
      bus.lsu_rsp_err_i   = lsu_acc & lsu_rsp_on & lsu_err_inj;
    end
  end

  initial begin
    clear_inputs();
    rst_i = 1'b1;

    // Reset state.
    do_reset();
    check_all_zero("rst");

    // Three ALU instructions: commits in cycles 4, 8, 12; IR latch in 2, 6, 10.
    bus.ifu_req_ready_i = 1'b1;
    bus.lsu_req_ready_i = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      step();
      check_eq("alu_wb_en", {63'd0, wb_en_o}, {63'd0, (k == 4 || k == 8 || k == 12)});
      check_eq("alu_latch", {63'd0, bus.inst_latch_en_o}, {63'd0, (k % 4 == 2)});
      check_eq("alu_busy", {63'd0, busy_o}, 64'd1);
    end
    check_eq("alu_retired", retired_o, 64'd3);

    // Load with LSU ready low 5 cycles: valid held cycles 16..21, commit in 23.
    idu_is_load_i       = 1'b1;
    bus.lsu_req_ready_i = 1'b0;
    cnt_a  = 0;
    cnt_b  = 0;
    wb_cyc = 0;
    for (int k = 14; k <= 24; k++) begin
      step();
      if (bus.lsu_req_valid_o) cnt_a++;
      if (wb_en_o) begin
        cnt_b++;
        wb_cyc = k;
      end
      if (k == 21) bus.lsu_req_ready_i = 1'b1;
    end
    check_eq("ld_valid_hold", 64'(cnt_a), 64'd6);
    check_eq("ld_wb_count", 64'(cnt_b), 64'd1);
    check_eq("ld_retire_gap", 64'(wb_cyc - 12), 64'd11);
    check_eq("ld_retired", retired_o, 64'd4);

    // ebreak: EXEC in cycle 26, halted from 27; later responses ignored.
    idu_is_load_i   = 1'b0;
    idu_is_ebreak_i = 1'b1;
    cnt_b = 0;
    for (int k = 25; k <= 34; k++) begin
      step();
      if (wb_en_o) cnt_b++;
      check_eq("eb_halt", {63'd0, halt_o}, {63'd0, (k >= 27)});
      check_eq("eb_latch", {63'd0, bus.inst_latch_en_o}, {63'd0, (k == 25)});
      if (k == 29) ifu_force = 1'b1;
    end
    check_eq("eb_wb_count", 64'(cnt_b), 64'd0);
    check_eq("eb_code", {62'd0, halt_code_o}, 64'd1);
    check_eq("eb_retired", retired_o, 64'd4);
    check_eq("eb_busy", {63'd0, busy_o}, 64'd0);
    check_eq("eb_ifu_valid", {63'd0, bus.ifu_req_valid_o}, 64'd0);

    // Fetch access fault: error response in cycle 2, halted from 3.
    do_reset();
    bus.ifu_req_ready_i = 1'b1;
    ifu_err_inj = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      check_eq("if_err_latch", {63'd0, bus.inst_latch_en_o}, 64'd0);
      check_eq("if_err_halt", {63'd0, halt_o}, {63'd0, (k >= 3)});
    end
    check_eq("if_err_code", {62'd0, halt_code_o}, 64'd2);

    // Store data fault: WAIT_D error in cycle 5, halted from 6, no commit.
    do_reset();
    bus.ifu_req_ready_i = 1'b1;
    bus.lsu_req_ready_i = 1'b1;
    idu_is_store_i = 1'b1;
    lsu_err_inj    = 1'b1;
    cnt_b = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (wb_en_o) cnt_b++;
      check_eq("st_err_lsu_valid", {63'd0, bus.lsu_req_valid_o}, {63'd0, (k == 4)});
      check_eq("st_err_halt", {63'd0, halt_o}, {63'd0, (k >= 6)});
    end
    check_eq("st_err_wb_count", 64'(cnt_b), 64'd0);
    check_eq("st_err_code", {62'd0, halt_code_o}, 64'd2);
    check_eq("st_err_retired", retired_o, 64'd0);

    // Reset in WAIT_D: one ALU retire, then a load whose data never returns.
    do_reset();
    bus.ifu_req_ready_i = 1'b1;
    bus.lsu_req_ready_i = 1'b1;
    lsu_rsp_on = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      step();
      if (k == 5) idu_is_load_i = 1'b1;
    end
    check_eq("mid_busy", {63'd0, busy_o}, 64'd1);
    check_eq("mid_retired", retired_o, 64'd1);
    rst_i = 1'b1;
    step();
    check_all_zero("mid_rst");
    step();
    rst_i = 1'b0;
    idu_is_load_i = 1'b0;
    step();
    check_eq("mid_fetch", {63'd0, bus.ifu_req_valid_o}, 64'd1);
    check_eq("mid_busy_again", {63'd0, busy_o}, 64'd1);
    check_eq("mid_retired_clr", retired_o, 64'd0);

`ifdef EXEC_SEQ_CTRL_WDT_EN
    // No fetch response: WAIT_I entered in cycle 2, count 8 in cycle 10, halt from 11.
    do_reset();
    bus.ifu_req_ready_i = 1'b1;
    ifu_rsp_on = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      check_eq("wdt_halt", {63'd0, halt_o}, {63'd0, (k >= 11)});
    end
    check_eq("wdt_code", {62'd0, halt_code_o}, 64'd3);

    // Response in the count-8 cycle wins: EXEC in cycle 11, no halt.
    do_reset();
    bus.ifu_req_ready_i = 1'b1;
    ifu_rsp_on = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      step();
      if (k == 9)  ifu_force = 1'b1;
      if (k == 10) begin
        check_eq("wdt_race_latch", {63'd0, bus.inst_latch_en_o}, 64'd1);
        ifu_force = 1'b0;
      end
    end
    check_eq("wdt_race_halt", {63'd0, halt_o}, 64'd0);
    check_eq("wdt_race_busy", {63'd0, busy_o}, 64'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/exec_seq_ctrl.md
Name: exec_seq_ctrl

Overview:
- Multi-cycle sequencer for the core.
- Drives the fetch handshake, the load/store handshake and the writeback-enable pulse that commits npc into the PC register.
- Sits between the PC update unit, the IFU/LSU memory ports and the decoder flags.
- Retires exactly one instruction per pass; halts on ebreak or access fault.

Parameters:
- RETIRE_W, 64, width of the retired-instruction counter.
- WDT_LIMIT, 1023, maximum wait cycles for a memory response (optional feature only).
- WDT_W, 10, width of the watchdog counter; must satisfy 2^WDT_W > WDT_LIMIT.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- ifu_req_valid_o  out  1  fetch request
- ifu_req_ready_i  in  1  IFU accepts request
- ifu_rsp_valid_i  in  1  instruction returned
- ifu_rsp_err_i  in  1  fetch access fault (qualified by ifu_rsp_valid_i)
- inst_latch_en_o  out  1  capture instruction into the IR
- idu_is_load_i  in  1  decoded load
- idu_is_store_i  in  1  decoded store
- idu_is_ebreak_i  in  1  decoded ebreak
- lsu_req_valid_o  out  1  data request
- lsu_req_ready_i  in  1  LSU accepts request
- lsu_rsp_valid_i  in  1  data access complete
- lsu_rsp_err_i  in  1  data access fault (qualified by lsu_rsp_valid_i)
- wb_en_o  out  1  commit pulse to the PC unit and the register file
- busy_o  out  1  high in any state except IDLE and HALT
- halt_o  out  1  core halted
- halt_code_o  out  2  0 none, 1 ebreak, 2 access fault, 3 watchdog
- retired_o  out  RETIRE_W  count of committed instructions

Behaviour:
- Reset: one clock, clk_i; rst_i synchronous and active-high. On reset: state is IDLE, all outputs 0, retired_o 0, halt_code_o 0.
- States and transitions: IDLE, FETCH, WAIT_I, EXEC, MEM_REQ, WAIT_D, WB, HALT.
- IDLE: go to FETCH the cycle after reset deasserts.
- FETCH:
  - ifu_req_valid_o=1 (Moore output).
  - ifu_req_ready_i=1 → WAIT_I; otherwise stay in FETCH with valid held.
- WAIT_I:
  - ifu_rsp_valid_i is honoured only in this state; responses in other states are ignored.
  - rsp_valid & !err: inst_latch_en_o=1 combinationally in the same cycle → EXEC.
  - rsp_valid & err: halt_code 2 → HALT.
- EXEC (exactly one cycle; decode flags sampled here):
  - Priority: ebreak first, then load/store, then other.
  - ebreak → HALT, halt_code 1, no wb_en. PC stays at the ebreak address.
  - load or store → MEM_REQ.
  - Otherwise → WB.
- MEM_REQ: lsu_req_valid_o=1 until lsu_req_ready_i → WAIT_D.
- WAIT_D:
  - lsu_rsp_valid_i & !err → WB.
  - With err → HALT, halt_code 2, no commit.
- WB: wb_en_o=1 for exactly one cycle; retired_o increments by 1 (wraps modulo 2^RETIRE_W) → FETCH.
- HALT: absorbing until reset. halt_o=1, busy_o=0, and no request or wb_en is ever asserted.
- Latency with ready tied high and responses one cycle after accept:
  - non-memory instruction: 4 cycles per retire (FETCH, WAIT_I, EXEC, WB).
  - load/store: 6 cycles per retire.
- Request valids are never withdrawn before ready is seen.
- Reset mid-transaction returns to IDLE immediately, with no commit. Memory-side cancellation is the memories' responsibility.
- halt_code_o is written only on entry to HALT and is stable thereafter.
- If both load and store flags are high, treat as one memory access.

Optional Feature:
- Macro: EXEC_SEQ_CTRL_WDT_EN.
- With the macro defined:
  - A WDT_W-bit counter clears on entry to WAIT_I or WAIT_D and increments each cycle spent waiting.
  - When it reaches WDT_LIMIT without a response → HALT, halt_code 3.
  - A response arriving in that same cycle wins over the timeout.
- Without the macro: no counter; waits are unbounded and halt_code 3 is never produced.

Decomposition:
- Shared package:
  - state encoding constants (3-bit; IDLE=0 … HALT=7);
  - halt_code constants;
  - RETIRE_W default.
- The reset value of the PC stays defined in the existing global defines.
- One natural sub-module, exec_seq_wdt: the watchdog counter and timeout compare, instantiated only under EXEC_SEQ_CTRL_WDT_EN.
- The FSM and retire counter stay in the top block.

Test Plan:
- Reset, then 3 ALU instructions; ready=1, responses at +1 cycle → wb_en pulses at cycles 4, 8, 12 after reset release; retired_o=3.
- Load with lsu_req_ready_i low for 5 cycles → lsu_req_valid_o held for 6 cycles; exactly one wb_en; retire interval 11 cycles.
- ebreak decoded in EXEC → halt_o=1 the next cycle, halt_code_o=1, no wb_en, retired_o unchanged; all later responses ignored.
- Fetch response with ifu_rsp_err_i=1 → HALT, code 2, inst_latch_en_o=0. Data error on a store → HALT, code 2, no wb_en.
- rst_i asserted while in WAIT_D → next cycle IDLE with all outputs 0; rst_i held 2 cycles then released → FETCH resumes, retired_o=0.
- Macro defined, WDT_LIMIT=8, no ifu response → HALT, code 3, exactly 8 cycles after entering WAIT_I. Response arriving at count 8 → EXEC taken, no halt.
